// File: rtl/risc_pkg.sv
// Shared register-file constants and write-back types used by the
// write-back controller and its load-result queue.
package risc_pkg;

    localparam int REG_ADDR_WIDTH = 4;
    localparam int REG_DATA_WIDTH = 16;
    localparam int REG_NUMBER     = 16;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [REG_DATA_WIDTH-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_ALU,
        SRC_LQ
    } wb_src_e;

endpackage

// File: rtl/wb_lq_fifo.sv
// Synchronous FIFO of write-back entries buffering load results until the
// shared regfile write port is free. Async active-low reset clears control only.
module wb_lq_fifo
    import risc_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  wb_entry_t     push_data,
    input  logic          pop,
    output wb_entry_t     pop_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    wb_entry_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/reg_wb_scoreboard.sv
// Regfile write-port arbiter (ALU over buffered loads) plus pending-register
// scoreboard for RAW/WAW stalls. Define WB_FWD_EN to add write-port forwarding.
module reg_wb_scoreboard #(
    parameter int REG_ADDR_WIDTH = risc_pkg::REG_ADDR_WIDTH,
    parameter int REG_DATA_WIDTH = risc_pkg::REG_DATA_WIDTH,
    parameter int REG_NUMBER     = risc_pkg::REG_NUMBER,
    parameter int LQ_DEPTH       = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      iss_valid,
    input  logic [REG_ADDR_WIDTH-1:0] iss_rd,
    output logic                      iss_ready,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    input  logic                      alu_valid,
    input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
    input  logic [REG_DATA_WIDTH-1:0] alu_data,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input  logic [REG_DATA_WIDTH-1:0] mem_data,
`ifdef WB_FWD_EN
    output logic                      rs1_fwd_valid,
    output logic [REG_DATA_WIDTH-1:0] rs1_fwd_data,
    output logic                      rs2_fwd_valid,
    output logic [REG_DATA_WIDTH-1:0] rs2_fwd_data,
`endif
    output logic [REG_ADDR_WIDTH-1:0] rd_addr,
    output logic [REG_DATA_WIDTH-1:0] rd_data,
    output logic                      RegWEn
);

    localparam int LQ_CNT_W = $clog2(LQ_DEPTH) + 1;

    risc_pkg::wb_entry_t lq_push_data, lq_head, sel_entry;
    risc_pkg::wb_src_e   sel_src;
    logic                lq_push, lq_pop, lq_full, lq_empty;
    logic [LQ_CNT_W-1:0] lq_count;

    logic [REG_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [REG_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                      wen_q, wen_d;
    logic [REG_NUMBER-1:0]     pending_q, pending_d;
    logic                      rs1_pend, rs2_pend;

    // Full means no push even if a pop frees a slot on the same edge.
    assign mem_ready         = (lq_count != LQ_CNT_W'(LQ_DEPTH));
    assign lq_push           = mem_valid && !lq_full;
    assign lq_push_data.rd   = mem_rd;
    assign lq_push_data.data = mem_data;

    wb_lq_fifo #(
        .DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk       (clk),
        .rst       (rst),
        .push      (lq_push),
        .push_data (lq_push_data),
        .pop       (lq_pop),
        .pop_data  (lq_head),
        .full      (lq_full),
        .empty     (lq_empty),
        .count     (lq_count)
    );

    always_comb begin
        sel_src   = risc_pkg::SRC_NONE;
        sel_entry = lq_head;
        if (alu_valid) begin
            sel_src        = risc_pkg::SRC_ALU;
            sel_entry.rd   = alu_rd;
            sel_entry.data = alu_data;
        end else if (!lq_empty) begin
            sel_src = risc_pkg::SRC_LQ;
        end
    end

    assign lq_pop = (sel_src == risc_pkg::SRC_LQ);

    // r0 results still consume their slot but never raise the write enable.
    always_comb begin
        wen_d     = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        if (sel_src != risc_pkg::SRC_NONE) begin
            wen_d     = (sel_entry.rd != '0);
            rd_addr_d = sel_entry.rd;
            rd_data_d = sel_entry.data;
        end
    end

    // Clear on the regfile write edge; a same-edge set overrides it.
    always_comb begin
        pending_d = pending_q;
        if (wen_q) pending_d[rd_addr_q] = 1'b0;
        if (iss_valid && iss_ready && (iss_rd != '0)) pending_d[iss_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_addr_q <= '0;
            rd_data_q <= '0;
            wen_q     <= 1'b0;
            pending_q <= '0;
        end else begin
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            wen_q     <= wen_d;
            pending_q <= pending_d;
        end
    end

    assign rd_addr   = rd_addr_q;
    assign rd_data   = rd_data_q;
    assign RegWEn    = wen_q;
    assign iss_ready = !pending_q[iss_rd];
    assign rs1_pend  = pending_q[rs1_addr] && (rs1_addr != '0);
    assign rs2_pend  = pending_q[rs2_addr] && (rs2_addr != '0);

`ifdef WB_FWD_EN
    assign rs1_fwd_valid = wen_q && (rd_addr_q == rs1_addr) && (rs1_addr != '0);
    assign rs2_fwd_valid = wen_q && (rd_addr_q == rs2_addr) && (rs2_addr != '0);
    assign rs1_fwd_data  = rd_data_q;
    assign rs2_fwd_data  = rd_data_q;
    assign rs1_busy      = rs1_pend && !rs1_fwd_valid;
    assign rs2_busy      = rs2_pend && !rs2_fwd_valid;
`else
    assign rs1_busy      = rs1_pend;
    assign rs2_busy      = rs2_pend;
`endif

endmodule

// File: tb/tb_reg_wb_scoreboard.sv
// Bench for reg_wb_scoreboard: directed scenarios plus random traffic, all
// compared each cycle against a queue/array reference model.
module tb_reg_wb_scoreboard;

    localparam int LQD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid, iss_ready;
    logic [3:0]  iss_rd, rs1_addr, rs2_addr;
    logic        rs1_busy, rs2_busy;
    logic        alu_valid;
    logic [3:0]  alu_rd;
    logic [15:0] alu_data;
    logic        mem_valid, mem_ready;
    logic [3:0]  mem_rd;
    logic [15:0] mem_data;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic        RegWEn;
`ifdef WB_FWD_EN
    logic        rs1_fwd_valid, rs2_fwd_valid;
    logic [15:0] rs1_fwd_data, rs2_fwd_data;
`endif

    always #5 clk = ~clk;

    reg_wb_scoreboard #(.LQ_DEPTH(LQD)) dut (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_ready (iss_ready),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
`ifdef WB_FWD_EN
        .rs1_fwd_valid (rs1_fwd_valid),
        .rs1_fwd_data  (rs1_fwd_data),
        .rs2_fwd_valid (rs2_fwd_valid),
        .rs2_fwd_data  (rs2_fwd_data),
`endif
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .RegWEn    (RegWEn)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: pending flags, queue of buffered loads, current write port.
    bit          m_pend [16];
    logic [19:0] m_q [$];
    bit          m_wen;
    int          m_addr;
    int          m_data;
    bit          last_acc;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_busy(input int a);
        bit b;
        b = m_pend[a] && (a != 0);
`ifdef WB_FWD_EN
        if (m_wen && (m_addr == a)) b = 1'b0;
`endif
        return b;
    endfunction

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_q.delete();
        m_wen    = 1'b0;
        m_addr   = 0;
        m_data   = 0;
        last_acc = 1'b0;
    endtask

    task automatic drive_idle();
        iss_valid = 1'b0; iss_rd = 4'd0;
        alu_valid = 1'b0; alu_rd = 4'd0; alu_data = 16'd0;
        mem_valid = 1'b0; mem_rd = 4'd0; mem_data = 16'd0;
        rs1_addr  = 4'd0; rs2_addr = 4'd0;
    endtask

    // One clock: drive, check combinational outputs, advance model, check write port.
    task automatic step(input int iv, input int ird, input int av, input int ard, input int ad,
                        input int mv, input int mrd, input int md, input int r1, input int r2);
        bit          iss_ok;
        bit          sel;
        int          srd, sdat;
        logic [19:0] ent;
        @(negedge clk);
        iss_valid = 1'(iv);  iss_rd   = 4'(ird);
        alu_valid = 1'(av);  alu_rd   = 4'(ard);  alu_data = 16'(ad);
        mem_valid = 1'(mv);  mem_rd   = 4'(mrd);  mem_data = 16'(md);
        rs1_addr  = 4'(r1);  rs2_addr = 4'(r2);
        #1;
        check_eq("mem_ready", mem_ready, m_q.size() < LQD);
        check_eq("iss_ready", iss_ready, !m_pend[ird]);
        check_eq("rs1_busy", rs1_busy, exp_busy(r1));
        check_eq("rs2_busy", rs2_busy, exp_busy(r2));
`ifdef WB_FWD_EN
        check_eq("rs1_fwd_valid", rs1_fwd_valid, m_wen && (m_addr == r1) && (r1 != 0));
        check_eq("rs2_fwd_valid", rs2_fwd_valid, m_wen && (m_addr == r2) && (r2 != 0));
        if (m_wen && (m_addr == r2)) check_eq("rs2_fwd_data", rs2_fwd_data, m_data);
`endif
        iss_ok   = !m_pend[ird];
        last_acc = (mv != 0) && (m_q.size() < LQD);
        sel = 1'b0; srd = 0; sdat = 0;
        if (av != 0) begin
            sel = 1'b1; srd = ard & 15; sdat = ad & 16'hFFFF;
        end else if (m_q.size() > 0) begin
            ent  = m_q.pop_front();
            sel  = 1'b1;
            srd  = int'(ent[19:16]);
            sdat = int'(ent[15:0]);
        end
        if (last_acc) m_q.push_back({4'(mrd), 16'(md)});
        if (m_wen) m_pend[m_addr] = 1'b0;
        if ((iv != 0) && iss_ok && (ird != 0)) m_pend[ird] = 1'b1;
        m_wen = sel && (srd != 0);
        if (sel) begin
            m_addr = srd;
            m_data = sdat;
        end
        @(posedge clk);
        #1;
        check_eq("RegWEn", RegWEn, m_wen);
        check_eq("rd_addr", rd_addr, m_addr);
        check_eq("rd_data", rd_data, m_data);
    endtask

    task automatic idle(input int r1, input int r2);
        step(0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        rmv;
        logic [3:0]  rmrd;
        logic [15:0] rmd;

        rst = 1'b0;
        drive_idle();
        model_reset();
        #1;
        check_eq("rst_RegWEn", RegWEn, 0);
        check_eq("rst_rd_addr", rd_addr, 0);
        check_eq("rst_rd_data", rd_data, 0);
        check_eq("rst_mem_ready", mem_ready, 1);
        @(negedge clk);
        rst = 1'b1;

        // ALU path: r5 busy through the write cycle, clear after
        step(1, 5, 0, 0, 0, 0, 0, 0, 5, 0);
        step(0, 0, 1, 5, 16'h1234, 0, 0, 0, 5, 0);
        check_eq("alu_wr_r5", {RegWEn, rd_addr, rd_data}, {1'b1, 4'd5, 16'h1234});
        idle(5, 5);
        idle(5, 5);

        // ALU priority starves the queued load
        step(0, 0, 0, 0, 0, 1, 2, 16'hAAAA, 0, 0);
        step(0, 0, 1, 4, 16'h0404, 0, 0, 0, 0, 0);
        step(0, 0, 1, 6, 16'h0606, 0, 0, 0, 0, 0);
        step(0, 0, 1, 7, 16'h0707, 0, 0, 0, 0, 0);
        idle(0, 0);
        check_eq("lq_after_alu", {RegWEn, rd_addr, rd_data}, {1'b1, 4'd2, 16'hAAAA});
        idle(0, 0);

        // Fill the queue behind a busy ALU, then a fifth load must be held
        for (int i = 0; i < 4; i++)
            step(0, 0, 1, 1, 16'h0100 + i, 1, i + 10, 16'hB000 + i, 0, 0);
        step(0, 0, 1, 1, 16'h01FF, 1, 14, 16'hBEEF, 0, 0);
        for (int k = 0; k < 20 && !last_acc; k++)
            step(0, 0, 0, 0, 0, 1, 14, 16'hBEEF, 0, 0);
        check_eq("lq5_accept", last_acc, 1);
        repeat (6) idle(0, 0);

        // WAW block on r9, then r0 traffic
        step(1, 9, 0, 0, 0, 0, 0, 0, 9, 0);
        step(1, 9, 0, 0, 0, 0, 0, 0, 9, 0);
        step(1, 9, 1, 9, 16'h0909, 0, 0, 0, 9, 0);
        step(1, 9, 0, 0, 0, 0, 0, 0, 9, 0);
        step(1, 9, 0, 0, 0, 0, 0, 0, 9, 0);
        step(0, 0, 1, 9, 16'h9999, 0, 0, 0, 9, 0);
        idle(9, 0);
        step(1, 0, 1, 0, 16'h5555, 1, 0, 16'h6666, 0, 0);
        idle(0, 0);
        idle(0, 0);

        // Write-port cycle with the destination on rs2
        step(1, 8, 0, 0, 0, 0, 0, 0, 0, 8);
        step(0, 0, 1, 8, 16'h00FF, 0, 0, 0, 0, 8);
        idle(8, 8);
        idle(8, 8);

        // Reset mid-run with r3 pending and two loads queued
        step(1, 3, 0, 0, 0, 0, 0, 0, 3, 0);
        step(0, 0, 1, 1, 16'h1111, 1, 12, 16'hC00C, 3, 0);
        step(0, 0, 1, 1, 16'h2222, 1, 13, 16'hD00D, 3, 0);
        @(negedge clk);
        drive_idle();
        rs1_addr = 4'd3;
        iss_rd   = 4'd3;
        rst      = 1'b0;
        #1;
        check_eq("mid_rst_RegWEn", RegWEn, 0);
        check_eq("mid_rst_rd_addr", rd_addr, 0);
        check_eq("mid_rst_rd_data", rd_data, 0);
        check_eq("mid_rst_rs1_busy", rs1_busy, 0);
        check_eq("mid_rst_iss_ready", iss_ready, 1);
        check_eq("mid_rst_mem_ready", mem_ready, 1);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (4) idle(3, 12);

        // Random traffic; the load producer holds its beat until accepted
        rmv = 1'b0; rmrd = 4'd0; rmd = 16'd0;
        repeat (400) begin
            if (!(rmv && !last_acc)) begin
                rmv  = 1'($urandom_range(1, 0));
                rmrd = 4'($urandom);
                rmd  = 16'($urandom);
            end
            step(int'($urandom_range(1, 0)), int'($urandom_range(15, 0)),
                 int'($urandom_range(2, 0) == 0), int'($urandom_range(15, 0)), int'($urandom_range(16'hFFFF, 0)),
                 int'(rmv), int'(rmrd), int'(rmd),
                 int'($urandom_range(15, 0)), int'($urandom_range(15, 0)));
        end
        repeat (8) idle(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_wb_scoreboard.md
Name: reg_wb_scoreboard

Overview:
- Write-side controller for the 16x16 register file.
- Merges single-cycle ALU results and buffered multi-cycle load results into the one regfile write port (rd_addr/rd_data/RegWEn).
- Keeps a per-register pending scoreboard so decode can stall on RAW and WAW hazards.
- Sits between execute/load units and the regfile; its outputs drive the regfile write port directly.

Parameters:
- REG_ADDR_WIDTH, 4, register address width.
- REG_DATA_WIDTH, 16, register data width.
- REG_NUMBER, 16, number of architectural registers; r0 is hard-wired to zero.
- LQ_DEPTH, 4, load-result FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- iss_valid  in  1  decode issues an instruction that writes iss_rd.
- iss_rd  in  REG_ADDR_WIDTH  destination of the issuing instruction.
- iss_ready  out  1  issue allowed: !pending[iss_rd] (WAW block); always 1 for r0.
- rs1_addr  in  REG_ADDR_WIDTH  decode source 1 query.
- rs2_addr  in  REG_ADDR_WIDTH  decode source 2 query.
- rs1_busy  out  1  pending[rs1_addr] && rs1_addr!=0.
- rs2_busy  out  1  pending[rs2_addr] && rs2_addr!=0.
- alu_valid  in  1  ALU result present; always accepted, no ready.
- alu_rd  in  REG_ADDR_WIDTH  ALU destination.
- alu_data  in  REG_DATA_WIDTH  ALU result.
- mem_valid  in  1  load result present.
- mem_ready  out  1  !lq_full; a transfer occurs when mem_valid && mem_ready.
- mem_rd  in  REG_ADDR_WIDTH  load destination.
- mem_data  in  REG_DATA_WIDTH  load data.
- rd_addr  out  REG_ADDR_WIDTH  registered regfile write address.
- rd_data  out  REG_DATA_WIDTH  registered regfile write data.
- RegWEn  out  1  registered regfile write enable.

Behaviour:
- Reset (rst=0, async):
  - rd_addr=0, rd_data=0, RegWEn=0.
  - pending all 0.
  - LQ empty (count=0, pointers 0); mem_ready=1.
  - In-flight results are discarded.
- Select, each cycle:
  - If alu_valid, select ALU (priority).
  - Else if LQ not empty, select the LQ head and pop it on this edge.
  - Else select nothing.
- Output register: on the edge, RegWEn <= (selection exists && sel_rd!=0); rd_addr/rd_data <= selection.
  - When nothing is selected, RegWEn=0 and rd_addr/rd_data hold their previous values.
- Latency:
  - ALU: 1 cycle, alu_valid to RegWEn.
  - Load: min 2 cycles (push edge, then pop/select edge). There is no bypass around the LQ.
- LQ:
  - Push on mem_valid && mem_ready.
  - When full, mem_ready=0 even if a pop occurs that cycle; no simultaneous push into a full queue.
  - Simultaneous push and pop when not full: count unchanged.
  - Pointers wrap modulo LQ_DEPTH.
  - A sustained alu_valid starves the LQ; this is by design, because the ALU issue rate is bounded by decode stalls.
- Scoreboard:
  - Set pending[iss_rd] on the edge where iss_valid && iss_ready && iss_rd!=0.
  - Clear pending[rd_addr] on the edge where RegWEn=1, the same edge the regfile writes, so busy deasserts exactly when the regfile holds the new value.
  - Set and clear of the same index on one edge cannot occur, because iss_ready blocks pending registers. If it does occur, set wins.
- r0:
  - Never pending.
  - Results for r0 are consumed (LQ popped) with RegWEn=0.
- Results to a non-pending register are still written; no error is flagged.
- iss_ready, rs*_busy and mem_ready are combinational from registered state only; there is no combinational path from alu_*/mem_* inputs.

Optional Feature:
- Macro WB_FWD_EN.
- Defined:
  - Adds outputs rs1_fwd_valid, rs1_fwd_data, rs2_fwd_valid, rs2_fwd_data.
  - rsN_fwd_valid = RegWEn && rd_addr==rsN_addr && rsN_addr!=0; rsN_fwd_data = rd_data.
  - rsN_busy is suppressed whenever rsN_fwd_valid=1, saving one stall cycle.
- Undefined: those ports are absent; busy as specified above.

Decomposition:
- Shared package risc_pkg:
  - REG_ADDR_WIDTH, REG_DATA_WIDTH, REG_NUMBER constants.
  - wb_entry_t struct {rd, data}.
  - wb_src_e enum {SRC_NONE, SRC_ALU, SRC_LQ}.
- One sub-module: wb_lq_fifo, a parameterised synchronous FIFO of wb_entry_t with push/pop/full/empty/count, reset async active-low.

Test Plan:
- Reset mid-run:
  - Stimulus: issue r3, push 2 loads, assert rst=0.
  - Response: RegWEn=0, rd_addr=0, rd_data=0, rs busy=0, mem_ready=1 immediately; after release, no stale writes.
- ALU path:
  - Stimulus: iss r5; next cycle alu_valid rd=5 data=0x1234.
  - Response: next cycle RegWEn=1, rd_addr=5, rd_data=0x1234; rs1_addr=5 gives rs1_busy=1 until that edge, then 0.
- Priority/starvation:
  - Stimulus: LQ holds {r2,0xAAAA}; alu_valid for 3 cycles to r4, r6, r7.
  - Response: writes r4, r6, r7 in order, then r2=0xAAAA in the 4th write cycle.
- LQ full:
  - Stimulus: push 4 loads with alu_valid held high.
  - Response: mem_ready=0; a 5th mem_valid is held, not lost. After alu_valid drops, the 5 writes appear in FIFO order, and mem_ready re-asserts the cycle after the first pop.
- WAW and r0:
  - Stimulus: iss r9 twice consecutively.
  - Response: second issue sees iss_ready=0 until r9 is written.
  - Stimulus: iss_rd=0 plus alu_rd=0.
  - Response: iss_ready=1, RegWEn=0, pending unchanged.
- WB_FWD_EN:
  - Stimulus: RegWEn write r8=0x00FF while rs2_addr=8.
  - Response: rs2_fwd_valid=1, rs2_fwd_data=0x00FF, rs2_busy=0.
  - Stimulus: same with macro undefined.
  - Response: rs2_busy=1 that cycle.
